gf_chieny_search: RTL and testbench
===================================

GF_CHIENY_SEARCH -- requirements
Module: gf_chieny_search

Interface
REQ-001 Parameters SHALL be: m, default 4, GF(2^m) symbol width; irrpol, default 19, field primitive polynomial; n, default 15, codeword length in bits; t, default 2, maximum locator degree; pDAT_W, default 4, positions evaluated per word.
REQ-002 iclk  in  1  single clock; all state SHALL be on its rising edge.
REQ-003 ireset  in  1  reset, asynchronous, active-low.
REQ-004 iclkena  in  1  clock enable; when low, all state SHALL hold.
REQ-005 ival  in  1  word strobe; one codeword word evaluated per accepted cycle (ival & iclkena).
REQ-006 isop  in  1  first word of codeword; SHALL be qualified by ival.
REQ-007 iloc_poly  in  m x (t+1)  error locator coefficients Λ0..Λt; sampled only at ival & isop.
REQ-008 iloc_deg  in  clog2(t+1)  locator degree; sampled only at ival & isop.
REQ-009 ialpha_start  in  m x t  per-term start multipliers for position 0.
REQ-010 ialpha  in  m x t  per-term per-position step multipliers; quasi-static.
REQ-011 oval, osop, oeop  out  1 each  registered word strobe and frame marks.
REQ-012 oerr  out  pDAT_W  error flags; bit b is codeword position w*pDAT_W+b (LSB first).
REQ-013 oerr_cnt  out  clog2(n+1)  total flagged positions in frame; valid at oval & oeop.
REQ-014 odecfail  out  1  decoding failure; valid at oval & oeop.

Function
REQ-015 Word count SHALL be W = ceil(n/pDAT_W); an internal word counter SHALL run 0..W-1.
REQ-016 Position p term i SHALL be T_i(p) = Λi·ialpha_start[i]·ialpha[i]^p over GF(2^m) reduced by irrpol; T_0(p) = Λ0.
REQ-017 At ival & isop, term bit 0 SHALL be computed from iloc_poly and ialpha_start; the word counter SHALL be set to 1 if W>1.
REQ-018 Otherwise, at ival, term bit 0 SHALL be the stored bit pDAT_W-1 term times ialpha[i]; bit b SHALL be bit b-1 times ialpha[i].
REQ-019 All pDAT_W terms of the last position of each word SHALL be registered per i as the feedback state; t registers of m bits.
REQ-020 Sum S_b SHALL be the XOR of T_0..T_t at bit b; oerr[b] SHALL be 1 iff S_b == 0 and position w*pDAT_W+b < n.
REQ-021 Padding positions (>= n) in the last word SHALL be forced to oerr = 0 and SHALL NOT be counted.
REQ-022 Latency SHALL be 1 cycle: word accepted at edge k appears on oval/oerr after edge k.
REQ-023 oval SHALL follow the accepted ival; osop SHALL mark word 0; oeop SHALL mark word W-1.
REQ-024 After word W-1, the counter SHALL wrap to 0 and the block SHALL wait for isop.
REQ-025 Words with ival and no isop while waiting SHALL be dropped: no oval, and no state change.
REQ-026 The error counter SHALL be cleared by isop, accumulate popcount(oerr) per word, and saturate at n.
REQ-027 oerr_cnt SHALL include the final word's flags at the oeop cycle.
REQ-028 odecfail SHALL be 1 iff final count != iloc_deg sampled at that frame's isop.
REQ-029 oerr_cnt and odecfail SHALL hold until the next oeop.
REQ-030 isop mid-frame SHALL abort the current frame without oeop, then restart at word 0 with new coefficients.
REQ-031 With W == 1, isop and eop SHALL coincide in one word; osop and oeop SHALL both be asserted.
REQ-032 When iclkena is low, ival SHALL be ignored and outputs SHALL hold.

Reset
REQ-033 On ireset low, oval, osop, oeop, oerr, oerr_cnt, and odecfail SHALL be 0 asynchronously.
REQ-034 On ireset low, the counters, term registers, and stored degree SHALL be 0, and the block SHALL wait for isop.
REQ-035 Reset mid-frame SHALL discard the frame; after release, no oval SHALL occur before the next isop.

Verification
REQ-036 Cfg m=4, irrpol=19, n=15, t=2, pDAT_W=4 (W=4). Λ=(1,0,0), deg 0, four ival words -> oerr all 0 every word; oeop on word 3; oerr_cnt=0; odecfail=0.
REQ-037 Single root at position 5, deg 1 -> only word 1 oerr=4'b0010; oerr_cnt=1; odecfail=0.
REQ-038 Two roots at positions 0 and 14, deg 2 -> word0 oerr=4'b0001, word3 oerr=4'b0100; padding bit 3 is 0; oerr_cnt=2; odecfail=0.
REQ-039 Degree-2 locator with no roots in range -> oerr_cnt=0; odecfail=1.
REQ-040 isop at word 2 of a frame with new Λ -> no oeop for the first frame; the second frame completes with correct flags.
REQ-041 Gaps: ival low and iclkena low between words -> results identical to back-to-back input.
REQ-042 Reset mid-frame, then stray ival without isop -> no oval.

Source files
------------

// File: rtl/gf_chieny_search.sv
// rtl/gf_chieny_search.sv - parallel Chien search over GF(2^m), pDAT_W positions per word
// Λi sits at iloc_poly[m*i +: m]; the start/step multipliers of term i sit at [m*(i-1) +: m].
module gf_chieny_search #(
    parameter int m      = 4,
    parameter int irrpol = 19,
    parameter int n      = 15,
    parameter int t      = 2,
    parameter int pDAT_W = 4
) (
    input  logic                     iclk,
    input  logic                     ireset,
    input  logic                     iclkena,
    input  logic                     ival,
    input  logic                     isop,
    input  logic [m*(t+1)-1:0]       iloc_poly,
    input  logic [$clog2(t+1)-1:0]   iloc_deg,
    input  logic [m*t-1:0]           ialpha_start,
    input  logic [m*t-1:0]           ialpha,
    output logic                     oval,
    output logic                     osop,
    output logic                     oeop,
    output logic [pDAT_W-1:0]        oerr,
    output logic [$clog2(n+1)-1:0]   oerr_cnt,
    output logic                     odecfail
);

    localparam int W     = (n + pDAT_W - 1) / pDAT_W;
    localparam int CW    = (W > 1) ? $clog2(W) : 1;
    localparam int DW    = $clog2(t+1);
    localparam int NW    = $clog2(n+1);
    localparam int LASTV = n - (W-1)*pDAT_W;
    localparam int IRR   = irrpol;
    localparam logic [m-1:0]  POLY_LO = IRR[m-1:0];
    localparam logic [CW-1:0] LAST_W  = CW'(W-1);
    localparam logic [NW:0]   N_SAT   = (NW+1)'(n);

    function automatic logic [m-1:0] gf_mul(input logic [m-1:0] a, input logic [m-1:0] b);
        logic [m-1:0] acc;
        logic [m-1:0] sh;
        acc = '0;
        sh  = a;
        for (int k = 0; k < m; k++) begin
            if (b[k]) acc = acc ^ sh;
            sh = sh[m-1] ? ({sh[m-2:0], 1'b0} ^ POLY_LO) : {sh[m-2:0], 1'b0};
        end
        return acc;
    endfunction

    logic              r_busy;
    logic [CW-1:0]     r_wcnt;
    logic [m-1:0]      r_lam0;
    logic [m-1:0]      r_fb [1:t];
    logic [DW-1:0]     r_deg;
    logic [NW-1:0]     r_cnt;

    logic              w_acc;
    logic              w_start;
    logic              w_step;
    logic              w_take;
    logic [CW-1:0]     w_widx;
    logic              w_last;
    logic [m-1:0]      w_lam0;
    logic [m-1:0]      w_term [1:t][pDAT_W];
    logic [pDAT_W-1:0] w_err;
    logic [NW:0]       w_pop;
    logic [NW:0]       w_sum_raw;
    logic [NW-1:0]     w_sum;
    logic [DW-1:0]     w_deg;

    // Words outside a frame (no isop seen) are not taken at all.
    assign w_acc   = iclkena & ival;
    assign w_start = w_acc & isop;
    assign w_step  = w_acc & ~isop & r_busy;
    assign w_take  = w_start | w_step;
    assign w_widx  = w_start ? '0 : r_wcnt;
    assign w_last  = (w_widx == LAST_W);
    assign w_deg   = w_start ? iloc_deg : r_deg;

    always_comb begin
        logic [m-1:0] w_run;
        w_run  = '0;
        w_lam0 = w_start ? iloc_poly[m-1:0] : r_lam0;
        for (int i = 1; i <= t; i++) begin
            if (w_start)
                w_run = gf_mul(iloc_poly[m*i +: m], ialpha_start[m*(i-1) +: m]);
            else
                w_run = gf_mul(r_fb[i], ialpha[m*(i-1) +: m]);
            w_term[i][0] = w_run;
            for (int b = 1; b < pDAT_W; b++) begin
                w_run        = gf_mul(w_run, ialpha[m*(i-1) +: m]);
                w_term[i][b] = w_run;
            end
        end
    end

    always_comb begin
        logic [m-1:0] w_s;
        w_s   = '0;
        w_err = '0;
        w_pop = '0;
        for (int b = 0; b < pDAT_W; b++) begin
            w_s = w_lam0;
            for (int i = 1; i <= t; i++) w_s = w_s ^ w_term[i][b];
            // Only the last word can carry padding positions beyond n-1.
            w_err[b] = (w_s == '0) && !(w_last && (b >= LASTV));
            w_pop    = w_pop + (NW+1)'(w_err[b]);
        end
    end

    assign w_sum_raw = (w_start ? '0 : {1'b0, r_cnt}) + w_pop;
    assign w_sum     = (w_sum_raw > N_SAT) ? N_SAT[NW-1:0] : w_sum_raw[NW-1:0];

    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            r_busy   <= 1'b0;
            r_wcnt   <= '0;
            r_lam0   <= '0;
            r_deg    <= '0;
            r_cnt    <= '0;
            for (int i = 1; i <= t; i++) r_fb[i] <= '0;
            oval     <= 1'b0;
            osop     <= 1'b0;
            oeop     <= 1'b0;
            oerr     <= '0;
            oerr_cnt <= '0;
            odecfail <= 1'b0;
        end else if (iclkena) begin
            oval <= w_take;
            osop <= w_take & (w_widx == '0);
            oeop <= w_take & w_last;
            if (w_take) begin
                oerr   <= w_err;
                r_cnt  <= w_sum;
                r_lam0 <= w_lam0;
                r_deg  <= w_deg;
                for (int i = 1; i <= t; i++) r_fb[i] <= w_term[i][pDAT_W-1];
                if (w_last) begin
                    r_wcnt   <= '0;
                    r_busy   <= 1'b0;
                    oerr_cnt <= w_sum;
                    odecfail <= (w_sum != NW'(w_deg));
                end else begin
                    r_wcnt <= w_widx + CW'(1);
                    r_busy <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_gf_chieny_search.sv
// tb/tb_gf_chieny_search.sv - scoreboard bench for gf_chieny_search (m=4, n=15, t=2, 4 positions/word)
`timescale 1ns/1ps
module tb_gf_chieny_search;

    localparam int W = 4;
    localparam int N = 15;

    logic        iclk = 1'b0;
    logic        ireset = 1'b0;
    logic        iclkena = 1'b1;
    logic        ival = 1'b0;
    logic        isop = 1'b0;
    logic [11:0] iloc_poly = '0;
    logic [1:0]  iloc_deg = '0;
    logic [7:0]  ialpha_start = '0;
    logic [7:0]  ialpha = '0;
    logic        oval, osop, oeop, odecfail;
    logic [3:0]  oerr, oerr_cnt;

    always #5 iclk = ~iclk;

    gf_chieny_search #(.m(4), .irrpol(19), .n(15), .t(2), .pDAT_W(4)) dut (
        .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .ival(ival), .isop(isop),
        .iloc_poly(iloc_poly), .iloc_deg(iloc_deg), .ialpha_start(ialpha_start), .ialpha(ialpha),
        .oval(oval), .osop(osop), .oeop(oeop), .oerr(oerr), .oerr_cnt(oerr_cnt), .odecfail(odecfail)
    );

    typedef struct packed {
        logic       sop;
        logic       eop;
        logic [3:0] err;
        logic [3:0] cnt;
        logic       dfail;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          n_chk = 0;
    int          n_pass = 0;
    int          gexp[15];
    int          glog[16];
    int          st1, st2, al1, al2;
    int          m_cnt = 0;
    logic [11:0] cur_poly;
    logic [1:0]  cur_deg;
    logic        en_q = 1'b1;
    logic [11:0] snap = '0;
    logic [3:0]  hold_cnt = '0;
    logic        hold_fail = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return gexp[(glog[a] + glog[b]) % 15];
    endfunction

    function automatic logic [3:0] model_err(input logic [11:0] poly, input int w);
        logic [3:0] r;
        int p, s;
        r = '0;
        for (int b = 0; b < 4; b++) begin
            p = w*4 + b;
            if (p < N) begin
                s = int'(poly[3:0])
                  ^ gmul(int'(poly[7:4]),  gmul(st1, gexp[(glog[al1]*p) % 15]))
                  ^ gmul(int'(poly[11:8]), gmul(st2, gexp[(glog[al2]*p) % 15]));
                r[b] = (s == 0);
            end
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            tick();
            iclkena = 1'b1;
            ival    = 1'b0;
            isop    = 1'b0;
        end
    endtask

    task automatic send_word(input logic sop, input int w, input logic gaps);
        exp_t e;
        logic [3:0] er;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                tick();
                iclkena = 1'($urandom_range(0, 1));
                ival    = ~iclkena;
                isop    = ~iclkena & 1'($urandom_range(0, 1));
            end
        end
        tick();
        iclkena = 1'b1;
        ival    = 1'b1;
        isop    = sop;
        iloc_poly = sop ? cur_poly : 12'($urandom);
        iloc_deg  = sop ? cur_deg  : 2'($urandom);
        if (sop) m_cnt = 0;
        er = model_err(cur_poly, w);
        m_cnt += $countones(er);
        if (m_cnt > N) m_cnt = N;
        e.sop   = (w == 0);
        e.eop   = (w == W-1);
        e.err   = er;
        e.cnt   = 4'(m_cnt);
        e.dfail = (m_cnt != int'(cur_deg));
        q.push_back(e);
    endtask

    task automatic send_frame(input logic [11:0] poly, input logic [1:0] deg, input logic gaps, input int nw);
        cur_poly = poly;
        cur_deg  = deg;
        for (int w = 0; w < nw; w++) send_word(w == 0, w, gaps);
    endtask

    task automatic stray(input int k);
        repeat (k) begin
            tick();
            iclkena   = 1'b1;
            ival      = 1'b1;
            isop      = 1'b0;
            iloc_poly = 12'($urandom);
            @(negedge iclk);
            check("stray_oval", oval, 0);
        end
        tick();
        ival = 1'b0;
        @(negedge iclk);
        check("stray_oval", oval, 0);
    endtask

    function automatic int frame_count(input logic [11:0] poly);
        int c = 0;
        for (int w = 0; w < W; w++) c += $countones(model_err(poly, w));
        return c;
    endfunction

    always @(posedge iclk) en_q <= iclkena;

    always @(negedge iclk) begin
        if (ireset) begin
            if (!en_q) begin
                check("hold", {oval, osop, oeop, oerr, oerr_cnt, odecfail}, snap);
            end else if (oval) begin
                if (q.size() == 0) begin
                    check("unexp_oval", 1, 0);
                end else begin
                    mon_e = q.pop_front();
                    check("osop", osop, mon_e.sop);
                    check("oeop", oeop, mon_e.eop);
                    check("oerr", oerr, mon_e.err);
                    if (mon_e.eop) begin
                        check("oerr_cnt", oerr_cnt, mon_e.cnt);
                        check("odecfail", odecfail, mon_e.dfail);
                        hold_cnt  = mon_e.cnt;
                        hold_fail = mon_e.dfail;
                    end else begin
                        check("cnt_hold", oerr_cnt, hold_cnt);
                        check("fail_hold", odecfail, hold_fail);
                    end
                end
            end
        end
        snap = {oval, osop, oeop, oerr, oerr_cnt, odecfail};
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] p36, p37, p38, p39;
        int v;
        v = 1;
        for (int k = 0; k < 15; k++) begin
            gexp[k] = v;
            glog[v] = k;
            v = v << 1;
            if ((v & 16) != 0) v = v ^ 19;
        end
        glog[0] = 0;
        al1 = gexp[1];
        al2 = gexp[2];
        st1 = 1;
        st2 = 1;
        ialpha       = {4'(al2), 4'(al1)};
        ialpha_start = {4'(st2), 4'(st1)};

        p36 = {4'd0, 4'd0, 4'd1};
        p37 = {4'd0, 4'd1, 4'(gexp[5])};
        p38 = {4'd1, 4'(1 ^ gexp[14]), 4'(gexp[14])};
        p39 = '0;
        for (int c = 15; c >= 1; c--)
            if (frame_count({4'd1, 4'd1, 4'(c)}) == 0) p39 = {4'd1, 4'd1, 4'(c)};

        repeat (3) @(posedge iclk);
        @(negedge iclk);
        check("rst_oval", oval, 0);
        check("rst_osop", osop, 0);
        check("rst_oeop", oeop, 0);
        check("rst_oerr", oerr, 0);
        check("rst_cnt", oerr_cnt, 0);
        check("rst_fail", odecfail, 0);
        tick();
        ireset = 1'b1;

        stray(2);
        send_frame(p36, 2'd0, 1'b0, W);
        send_frame(p37, 2'd1, 1'b0, W);
        send_frame(p38, 2'd2, 1'b0, W);
        send_frame(p39, 2'd2, 1'b0, W);
        idle(2);

        send_frame(p37, 2'd1, 1'b0, 2);
        send_frame(p38, 2'd2, 1'b0, W);
        idle(2);

        st1 = gexp[2];
        st2 = gexp[4];
        ialpha_start = {4'(st2), 4'(st1)};
        send_frame(p38, 2'd2, 1'b1, W);
        send_frame(p37, 2'd1, 1'b1, W);
        send_frame(p36, 2'd0, 1'b1, W);
        idle(2);
        st1 = 1;
        st2 = 1;
        ialpha_start = {4'(st2), 4'(st1)};
        idle(1);

        cur_poly = p38;
        cur_deg  = 2'd2;
        send_word(1'b1, 0, 1'b0);
        send_word(1'b0, 1, 1'b0);
        idle(1);
        @(negedge iclk);
        #1;
        ireset    = 1'b0;
        hold_cnt  = '0;
        hold_fail = 1'b0;
        #1;
        check("rstm_oval", oval, 0);
        check("rstm_oerr", oerr, 0);
        check("rstm_cnt", oerr_cnt, 0);
        check("rstm_fail", odecfail, 0);
        tick();
        ireset = 1'b1;
        stray(3);
        send_frame(p37, 2'd1, 1'b0, W);
        idle(4);
        check("q_empty", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
